// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the ring FIFO and its read-side drain controller.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_FIFO_SIZE  = 3;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_VALID = 1'b1
  } drain_state_t;

endpackage

// File: rtl/fifo.sv
// Single-clock ring FIFO with write priority and combinational read data; it keeps no
// occupancy of its own, so overflow silently overwrites the oldest unread slot.
module fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_SIZE  = DEFAULT_FIFO_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signal_wr,
  input  logic                  signal_oe,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int PTR_WIDTH = (FIFO_SIZE > 1) ? $clog2(FIFO_SIZE) : 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;

  function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
    if (ptr == PTR_WIDTH'(FIFO_SIZE - 1))
      return '0;
    else
      return ptr + PTR_WIDTH'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (signal_wr) begin
      mem[wr_ptr] <= data_in;
      wr_ptr      <= next_ptr(wr_ptr);
    end else if (signal_oe) begin
      rd_ptr <= next_ptr(rd_ptr);
    end
  end

  assign data_out = mem[rd_ptr];

endmodule

// File: rtl/fifo_occ_counter.sv
// Occupancy tracker for the ring FIFO: saturating up/down count with empty/full flags
// and a single-cycle pulse when a write lands on a full FIFO.
module fifo_occ_counter
  import fifo_pkg::*;
#(
  parameter int FIFO_SIZE = DEFAULT_FIFO_SIZE,
  parameter int CNT_WIDTH = $clog2(FIFO_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow_pulse
);

  assign empty          = (count == '0);
  assign full           = (count == CNT_WIDTH'(FIFO_SIZE));
  assign overflow_pulse = inc && full;

  // Write has priority; a write into a full FIFO leaves the count pinned at FIFO_SIZE.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      if (!full)
        count <= count + CNT_WIDTH'(1);
    end else if (dec && !empty) begin
      count <= count - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/fifo_drain.sv
// Read-side controller for the ring FIFO: pops words into a registered valid/ready
// output stage and reports occupancy, full/empty and a sticky overflow flag.
module fifo_drain
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_SIZE  = DEFAULT_FIFO_SIZE,
  parameter int CNT_WIDTH  = $clog2(FIFO_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_wr,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_oe,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);

  drain_state_t state_q;
  drain_state_t state_d;
  logic         overflow_pulse;

  fifo_occ_counter #(
    .FIFO_SIZE (FIFO_SIZE),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_occ (
    .clk            (clk),
    .rst            (rst),
    .inc            (fifo_wr),
    .dec            (fifo_oe),
    .count          (count),
    .empty          (empty),
    .full           (full),
    .overflow_pulse (overflow_pulse)
  );

  // The FIFO ignores its output-enable while writing, so a pop is only issued on
  // write-free cycles; this also guarantees inc and dec never coincide.
  assign fifo_oe = !rst && !empty && !fifo_wr && ((state_q == S_IDLE) || m_ready);
  assign m_valid = (state_q == S_VALID);

  always_comb begin
    state_d = state_q;
    if (fifo_oe)
      state_d = S_VALID;
    else if ((state_q == S_VALID) && m_ready)
      state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      m_data   <= '0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fifo_oe)
        m_data <= fifo_data;
      if (overflow_pulse)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain driving a real ring FIFO; written words are queued as
// expectations and a negedge monitor checks every word the consumer accepts.
module tb_fifo_drain;
  import fifo_pkg::*;

  localparam int DW = DEFAULT_DATA_WIDTH;
  localparam int FS = DEFAULT_FIFO_SIZE;
  localparam int CW = $clog2(FS + 1);

  logic          clk;
  logic          rst;
  logic          fifo_wr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] fifo_data;
  logic          fifo_oe;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  fifo #(.DATA_WIDTH(DW), .FIFO_SIZE(FS)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .signal_wr (fifo_wr),
    .signal_oe (fifo_oe),
    .data_in   (wr_data),
    .data_out  (fifo_data)
  );

  fifo_drain #(.DATA_WIDTH(DW), .FIFO_SIZE(FS), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_wr   (fifo_wr),
    .fifo_data (fifo_data),
    .fifo_oe   (fifo_oe),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle's inputs just after the rising edge and returns at the falling edge.
  task automatic applyStimulus(input logic r, input logic wr, input logic [DW-1:0] d, input logic rdy);
    @(posedge clk);
    #1;
    rst     = r;
    fifo_wr = wr;
    wr_data = d;
    m_ready = rdy;
    if (r)
      exp_q.delete();
    else if (wr)
      exp_q.push_back(d);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected_word", m_data, '0);
        if (m_data === '0) begin
          n_fail++;
          $display("[TB] FAIL sb_unexpected_word: got a word, expected none at %0t", $time);
        end
      end else begin
        checkOutput("sb_m_data", m_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst     = 1'b1;
    fifo_wr = 1'b0;
    wr_data = '0;
    m_ready = 1'b0;

    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
      checkOutput("rst_oe", 32'(fifo_oe), 0);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_empty", 32'(empty), 1);
    checkOutput("rst_full", 32'(full), 0);
    checkOutput("rst_m_valid", 32'(m_valid), 0);
    checkOutput("rst_m_data", m_data, 0);
    checkOutput("rst_overflow", 32'(overflow), 0);
    checkOutput("rst_oe_after", 32'(fifo_oe), 0);

    // Single word
    applyStimulus(1'b0, 1'b1, 32'hA5A50001, 1'b1);
    checkOutput("single_oe_wr", 32'(fifo_oe), 0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("single_oe_pop", 32'(fifo_oe), 1);
    checkOutput("single_count1", 32'(count), 1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("single_oe_done", 32'(fifo_oe), 0);
    checkOutput("single_m_valid", 32'(m_valid), 1);
    checkOutput("single_m_data", m_data, 32'hA5A50001);
    checkOutput("single_count0", 32'(count), 0);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("single_idle", 32'(m_valid), 0);

    // Fill with backpressure
    applyStimulus(1'b0, 1'b1, 32'h11, 1'b0);
    checkOutput("fill_oe0", 32'(fifo_oe), 0);
    applyStimulus(1'b0, 1'b1, 32'h22, 1'b0);
    checkOutput("fill_oe1", 32'(fifo_oe), 0);
    applyStimulus(1'b0, 1'b1, 32'h33, 1'b0);
    checkOutput("fill_oe2", 32'(fifo_oe), 0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("fill_count3", 32'(count), 3);
    checkOutput("fill_full", 32'(full), 1);
    checkOutput("fill_first_pop", 32'(fifo_oe), 1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("fill_hold_valid", 32'(m_valid), 1);
    checkOutput("fill_hold_data", m_data, 32'h11);
    checkOutput("fill_count2", 32'(count), 2);
    checkOutput("fill_hold_oe", 32'(fifo_oe), 0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("fill_stable_data", m_data, 32'h11);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("drain_oe", 32'(fifo_oe), (i < 2) ? 1 : 0);
    end
    checkOutput("drain_empty", 32'(empty), 1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);

    // Overflow: hold one word in the output stage so nothing drains
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h41, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h42, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h43, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h44, 1'b0);
    checkOutput("ovf_pre_count", 32'(count), 3);
    checkOutput("ovf_pre_flag", 32'(overflow), 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b0);
      checkOutput("ovf_flag", 32'(overflow), 1);
      checkOutput("ovf_count", 32'(count), 3);
      checkOutput("ovf_no_oe", 32'(fifo_oe), 0);
    end
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("ovf_cleared", 32'(overflow), 0);
    checkOutput("ovf_rst_count", 32'(count), 0);

    // Wrap-around: one write every other cycle
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b0, 1'b1, DW'(k), 1'b1);
      checkOutput("wrap_count_wr", 32'(count), 0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("wrap_count_pop", 32'(count), 1);
      checkOutput("wrap_oe", 32'(fifo_oe), 1);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("wrap_last", m_data, 32'h7);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);

    // Reset mid-stream with count=2 and a word held in the output stage
    applyStimulus(1'b0, 1'b1, 32'h50, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h51, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h52, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("mid_count2", 32'(count), 2);
    checkOutput("mid_valid", 32'(m_valid), 1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    checkOutput("mid_rst_oe", 32'(fifo_oe), 0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("mid_count", 32'(count), 0);
    checkOutput("mid_empty", 32'(empty), 1);
    checkOutput("mid_m_valid", 32'(m_valid), 0);
    checkOutput("mid_m_data", m_data, 0);
    applyStimulus(1'b0, 1'b1, 32'h55, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("mid_first_word", m_data, 32'h55);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);

    checkOutput("sb_all_consumed", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_drain.md
# fifo_drain

Read-side controller placed directly downstream of the single-clock ring FIFO. It snoops the FIFO's write strobe to track occupancy, issues the FIFO's output-enable only when a word is present and accepted, and re-times the FIFO's combinational read data into a registered valid/ready stream. The block also supplies the full/empty/overflow status that the FIFO itself does not provide.

## Interface
- DATA_WIDTH, 32: word width; must match the FIFO.
- FIFO_SIZE, 3: FIFO depth in words; must match the FIFO.
- CNT_WIDTH, $clog2(FIFO_SIZE+1): occupancy counter width.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset; the same net resets the FIFO.
- fifo_wr  in  1  snoop of the FIFO write strobe (signal_wr).
- fifo_data  in  DATA_WIDTH  FIFO read data (data_out); valid in the same cycle as fifo_oe.
- fifo_oe  out  1  to the FIFO signal_oe; pops one word per cycle asserted.
- m_data  out  DATA_WIDTH  output word, registered.
- m_valid  out  1  m_data holds an unconsumed word.
- m_ready  in  1  consumer accepts m_data.
- count  out  CNT_WIDTH  words resident in the FIFO, excluding the output register.
- empty  out  1  count == 0.
- full  out  1  count == FIFO_SIZE; the upstream writer must not assert fifo_wr.
- overflow  out  1  sticky error flag.

## Operation
- FSM with two states. S_IDLE: output register empty, m_valid=0. S_VALID: output register loaded, m_valid=1.
- fifo_oe = !rst && !empty && !fifo_wr && (state==S_IDLE || m_ready). The path is combinational from fifo_wr and m_ready.
- fifo_oe is suppressed whenever fifo_wr=1 because the FIFO gives the write priority and does not advance its read pointer. This rule also means a read and a write never occur in the same cycle.
- On an edge with fifo_oe=1: m_data <= fifo_data, state <= S_VALID, count decrements.
- On an edge with state==S_VALID, m_ready=1 and fifo_oe=0: state <= S_IDLE. m_data holds its last value.
- On an edge with fifo_wr=1 and !full: count increments.
- On an edge with fifo_wr=1 and full: count saturates at FIFO_SIZE and overflow <= 1. The FIFO has already overwritten the oldest unread slot. overflow stays set until rst.
- Arithmetic: count is unsigned CNT_WIDTH. It never wraps and never underflows, because fifo_oe requires !empty.

## Timing
- Reset values (edge with rst=1): count=0, empty=1, full=0, overflow=0, m_valid=0, m_data=0, state=S_IDLE. fifo_oe=0 throughout the reset cycle.
- Reset mid-operation discards the contents of the output register and the occupancy count. The next word written after reset is the next word output.
- Latency:
  - Write at edge N: count=1 after edge N.
  - fifo_oe is asserted during cycle N..N+1 if fifo_wr=0.
  - m_valid=1 with that word after edge N+1.
- Throughput: one word per cycle while the FIFO is non-empty, no write is in progress and m_ready=1.
- m_data and m_valid are stable while m_valid=1 and m_ready=0.
- Continuous writes stall draining. Upstream must leave gaps, which is guaranteed by honouring full.

## Structure
- Shared package fifo_pkg holds:
  - the default DATA_WIDTH and FIFO_SIZE constants, shared with the FIFO;
  - the state enum (S_IDLE, S_VALID).
- Sub-module fifo_occ_counter:
  - takes inc, dec, rst;
  - produces count, empty and full, with saturation and the overflow pulse.
- The top level contains the FSM, the fifo_oe logic and the output register.
- Top-level test harness instantiates fifo + fifo_drain with shared clk/rst.

## Test plan
- Reset: hold rst for 2 cycles with random inputs -> count=0, empty=1, m_valid=0, m_data=0, fifo_oe=0, overflow=0.
- Single word: write 0xA5A50001 with m_ready=1 -> fifo_oe high for exactly one cycle. After the next edge, m_valid=1 with m_data=0xA5A50001 and count=0.
- Fill with backpressure: write 0x11, 0x22, 0x33 back-to-back with m_ready=0.
  - Expect count=3, full=1 and no fifo_oe during the writes.
  - Then m_valid shows 0x11 with count=2, and no further fifo_oe.
  - Raise m_ready -> 0x22 then 0x33 on consecutive cycles; empty=1 afterwards.
- Overflow: with count=3, force a 4th write of 0x44 -> overflow=1 and count=3. overflow remains 1 until rst.
- Wrap-around: write 0x01..0x07 every other cycle with m_ready=1 -> output order 0x01..0x07 and count never exceeds 1.
- Reset mid-stream: assert rst with count=2 and m_valid=1 -> all outputs take their reset values after the edge. A subsequent write of 0x55 is the first word output.
